// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants, fetch state type and alignment helper
// Purpose: types and constants shared by the instruction-fetch stage files.
// Ports: none (package).
package mips_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_FAULT
  } fetch_state_t;

  // Instructions are word-aligned: the two low address bits must be zero.
  function automatic logic is_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/mips_fetch_stage_if.sv
// rtl/mips_fetch_stage_if.sv - instruction memory and core handshake bundle
// Purpose: groups the instruction-memory request/response channel and the
// fetch-to-core presentation channel.
// Ports (signals):
//   imem_req_valid/imem_req_ready/imem_addr   request to instruction memory
//   imem_rsp_valid/imem_rsp_data              response from instruction memory
//   if_valid/if_ready/if_pc/if_instr          instruction presented to the core
//   next_pc                                   core's computed next address
// Modports: master = fetch stage, slave = memory + core side.
interface mips_fetch_stage_if #(
  parameter int ADDR_W = mips_pkg::ADDR_W
);
  import mips_pkg::*;

  logic                imem_req_valid;
  logic                imem_req_ready;
  logic [ADDR_W-1:0]   imem_addr;
  logic                imem_rsp_valid;
  logic [INSTR_W-1:0]  imem_rsp_data;
  logic                if_valid;
  logic                if_ready;
  logic [ADDR_W-1:0]   if_pc;
  logic [INSTR_W-1:0]  if_instr;
  logic [ADDR_W-1:0]   next_pc;

  modport master (
    output imem_req_valid, imem_addr, if_valid, if_pc, if_instr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready, next_pc
  );

  modport slave (
    input  imem_req_valid, imem_addr, if_valid, if_pc, if_instr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready, next_pc
  );

endinterface

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - program counter register with load enable and alignment check
// Purpose: holds the PC; loads d on load only when d is word-aligned.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (q <= RESET_PC)
//   load         load request (taken only if d is aligned)
//   d            candidate next PC
//   q            current PC
//   misaligned   combinational: d has nonzero low bits
module pc_reg
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = mips_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] d,
  output logic [ADDR_W-1:0] q,
  output logic              misaligned
);

  assign misaligned = !is_aligned(d[1:0]);

  // A misaligned target leaves the PC pointing at the faulting instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_PC;
    end else if (load && !misaligned) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mips_fetch_stage.sv
// rtl/mips_fetch_stage.sv - instruction fetch stage feeding the single-cycle core
// Purpose: owns the PC, requests instruction words, holds the returned word and
// presents {pc, instr} to the core; loads the core's next_pc on each retire.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   halt        stop fetching (sampled in IDLE and on retire)
//   bus         mips_fetch_stage_if.master: imem request/response, core handshake
//   fault       sticky misaligned-next_pc flag (cleared only by reset)
//   retired     count of retired instructions (wraps)
module mips_fetch_stage
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = mips_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 halt,
  mips_fetch_stage_if.master   bus,
  output logic                 fault,
  output logic [31:0]          retired
);

  fetch_state_t         state, state_next;
  logic [INSTR_W-1:0]   instr_q;
  logic [ADDR_W-1:0]    pc;
  logic                 pc_misaligned;
  logic                 retire;

  assign retire = (state == ST_HOLD) && bus.if_ready;

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (retire),
    .d          (bus.next_pc),
    .q          (pc),
    .misaligned (pc_misaligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (!halt) state_next = ST_REQ;
      ST_REQ:   if (bus.imem_req_ready) state_next = ST_WAIT;
      ST_WAIT:  if (bus.imem_rsp_valid) state_next = ST_HOLD;
      ST_HOLD: begin
        if (bus.if_ready) begin
          if (pc_misaligned) state_next = ST_FAULT;
          else if (halt)     state_next = ST_IDLE;
          else               state_next = ST_REQ;
        end
      end
      ST_FAULT: state_next = ST_FAULT;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Responses are only meaningful in WAIT; anything else (stale after reset,
  // stray in IDLE/FAULT) is dropped here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
    end else if (state == ST_WAIT && bus.imem_rsp_valid) begin
      instr_q <= bus.imem_rsp_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired <= '0;
      fault   <= 1'b0;
    end else if (retire) begin
      retired <= retired + 32'd1;
      if (pc_misaligned) fault <= 1'b1;
    end
  end

  // Moore outputs: decoded from state only.
  assign bus.imem_req_valid = (state == ST_REQ);
  assign bus.imem_addr      = pc;
  assign bus.if_valid       = (state == ST_HOLD);
  assign bus.if_pc          = pc;
  assign bus.if_instr       = instr_q;

endmodule

// File: tb/tb_mips_fetch_stage.sv
// tb/tb_mips_fetch_stage.sv - self-checking bench for mips_fetch_stage
module tb_mips_fetch_stage;
  import mips_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        halt;
  logic        fault;
  logic [31:0] retired;

  mips_fetch_stage_if #(.ADDR_W(32)) bus ();

  mips_fetch_stage #(
    .ADDR_W   (32),
    .RESET_PC (RST_PC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .halt    (halt),
    .bus     (bus),
    .fault   (fault),
    .retired (retired)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Transaction-level reference: where the next fetch should go, how many
  // instructions have retired, and whether a misaligned target was seen.
  logic [31:0] m_pc;
  logic [31:0] m_ret;
  logic        m_fault;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (bus.imem_req_valid !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    chk("req_seen", {31'd0, bus.imem_req_valid}, 32'd1);
  endtask

  // One full fetch/retire transaction with the given memory and core delays.
  task automatic do_instr(input int rdly, input int rspd, input int bp,
                          input logic [31:0] npc, input logic hlt,
                          input logic [31:0] word);
    logic [1:0] low;
    wait_req();
    chk("req_addr", bus.imem_addr, m_pc);
    for (int k = 0; k < rdly; k++) begin
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'($urandom);
      bus.imem_rsp_data  = $urandom;
      step();
      chk("req_held", {31'd0, bus.imem_req_valid}, 32'd1);
      chk("addr_stable", bus.imem_addr, m_pc);
    end
    bus.imem_req_ready = 1'b1;
    step();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    chk("wait_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
    chk("wait_no_valid", {31'd0, bus.if_valid}, 32'd0);
    if (hlt) halt = 1'b1;
    for (int r = 0; r < rspd; r++) begin
      step();
      chk("wait_no_valid", {31'd0, bus.if_valid}, 32'd0);
      chk("wait_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
    end
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = word;
    step();
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = $urandom;
    chk("hold_valid", {31'd0, bus.if_valid}, 32'd1);
    chk("hold_pc", bus.if_pc, m_pc);
    chk("hold_instr", bus.if_instr, word);
    for (int b = 0; b < bp; b++) begin
      bus.if_ready       = 1'b0;
      bus.imem_rsp_valid = 1'($urandom);
      bus.next_pc        = $urandom;
      step();
      chk("bp_valid", {31'd0, bus.if_valid}, 32'd1);
      chk("bp_pc", bus.if_pc, m_pc);
      chk("bp_instr", bus.if_instr, word);
      chk("bp_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
      chk("bp_retired", retired, m_ret);
    end
    bus.imem_rsp_valid = 1'b0;
    bus.if_ready       = 1'b1;
    bus.next_pc        = npc;
    step();
    bus.if_ready = 1'b0;
    m_ret = m_ret + 32'd1;
    low = npc[1:0];
    if (low == 2'b00) m_pc = npc;
    else m_fault = 1'b1;
    chk("retired", retired, m_ret);
    chk("fault", {31'd0, fault}, {31'd0, m_fault});
    chk("post_no_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("post_req", {31'd0, bus.imem_req_valid}, {31'd0, !m_fault && !halt});
  endtask

  initial begin
    rst_n              = 1'b0;
    halt               = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.if_ready       = 1'b0;
    bus.next_pc        = '0;
    m_pc    = RST_PC;
    m_ret   = 0;
    m_fault = 1'b0;

    // Reset state.
    #12;
    chk("rst_req", {31'd0, bus.imem_req_valid}, 32'd0);
    chk("rst_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_addr", bus.imem_addr, RST_PC);
    chk("rst_instr", bus.if_instr, 32'd0);
    step();
    rst_n = 1'b1;
    chk("rel_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
    step();

    // Zero-wait memory, sequential addresses.
    do_instr(0, 0, 0, 32'h4, 1'b0, 32'h0000_0028);
    do_instr(0, 0, 0, 32'h8, 1'b0, $urandom);
    // Memory wait states at 0x8.
    do_instr(2, 3, 0, 32'hC, 1'b0, 32'hDEAD_BEEF);
    // Core backpressure, jump to 0x40.
    do_instr(0, 0, 4, 32'h40, 1'b0, $urandom);
    // Halt while waiting on memory.
    do_instr(0, 1, 0, 32'h80, 1'b1, $urandom);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("halt_idle", {31'd0, bus.imem_req_valid}, 32'd0);
    end
    halt = 1'b0;
    step();
    chk("resume_req", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("resume_addr", bus.imem_addr, 32'h80);

    // Randomized transactions against the reference.
    for (int t = 0; t < 25; t++) begin
      logic h;
      h = ($urandom_range(0, 4) == 0);
      do_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom & 32'hFFFF_FFFC, h, $urandom);
      if (h) begin
        step();
        chk("rnd_halt_idle", {31'd0, bus.imem_req_valid}, 32'd0);
        halt = 1'b0;
        step();
      end
    end

    // Reset during WAIT; the late response must be ignored.
    wait_req();
    bus.imem_req_ready = 1'b1;
    step();
    bus.imem_req_ready = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hBAD0_BAD0;
    step();
    bus.imem_rsp_valid = 1'b0;
    m_pc  = RST_PC;
    m_ret = 0;
    chk("rstw_no_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("rstw_req", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("rstw_addr", bus.imem_addr, RST_PC);
    chk("rstw_retired", retired, 32'd0);
    do_instr(1, 0, 1, 32'h100, 1'b0, 32'h1234_5678);

    // Misaligned next_pc: terminal fault, pc unchanged.
    do_instr(0, 0, 0, 32'h12, 1'b0, $urandom);
    for (int i = 0; i < 5; i++) begin
      bus.imem_rsp_valid = 1'($urandom);
      bus.if_ready       = 1'($urandom);
      step();
      chk("flt_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
      chk("flt_no_valid", {31'd0, bus.if_valid}, 32'd0);
      chk("flt_sticky", {31'd0, fault}, 32'd1);
      chk("flt_pc", bus.imem_addr, m_pc);
    end
    bus.imem_rsp_valid = 1'b0;
    bus.if_ready       = 1'b0;
    rst_n = 1'b0;
    step();
    chk("flt_rst_clear", {31'd0, fault}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("flt_rst_req", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("flt_rst_addr", bus.imem_addr, RST_PC);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
